// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    // Requester ids carried through a transaction
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    // SRAM strobes are active-low
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/sram_arb_grant.sv
// Priority select between fetch and data ports with a starvation guard:
// data wins unless fetch has been passed over STARVE_LIMIT times in a row.
module sram_arb_grant
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    input  logic grant_take,
    output logic grant_id,
    output logic grant_valid
);

    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [CW-1:0] starve_cnt;
    logic          if_due;

    // Combinational priority; fetch forced through once it has waited long enough
    always_comb begin
        if_due      = if_req && (starve_cnt == CW'(STARVE_LIMIT));
        grant_valid = if_req || dm_req;
        grant_id    = (dm_req && !if_due) ? REQ_DM : REQ_IF;
    end

    // Count data grants taken while fetch was waiting; any fetch grant clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_take) begin
            if (grant_id == REQ_IF)
                starve_cnt <= '0;
            else if (if_req)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between instruction fetch and data ports.
// Each transaction: grant in IDLE, strobe sequence, one DONE turnaround
// cycle carrying the ack. Optional counters under SRAM_ARB_STATS_EN.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 32,
    parameter int WRITE_CYCLES = 2,
    parameter int STARVE_LIMIT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            ram_read_wait,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ack,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_ce,
    output logic                  ram_oe,
    output logic                  ram_we
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]           stat_if_grants,
    output logic [15:0]           stat_dm_grants,
    output logic [15:0]           stat_wait_cycles
`endif
);

    state_t                state, nxt;
    logic                  gid_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [7:0]            cnt;
    logic                  grant_id, grant_valid, take, drive;

    assign take = (state == IDLE) && grant_valid;

    sram_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .dm_req      (dm_req),
        .grant_take  (take),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // State register; async reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // Next-state: cnt counts down remaining READ / WR_PULSE cycles
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (take) nxt = (grant_id == REQ_DM && dm_we) ? WR_SETUP : READ;
            READ:     if (cnt == 8'd0) nxt = DONE;
            WR_SETUP: nxt = WR_PULSE;
            WR_PULSE: if (cnt == 8'd0) nxt = WR_HOLD;
            WR_HOLD:  nxt = DONE;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // Strobes, data drive and acks decoded from state alone
    always_comb begin
        ram_ce = STROBE_OFF;
        ram_oe = STROBE_OFF;
        ram_we = STROBE_OFF;
        drive  = 1'b0;
        if_ack = 1'b0;
        dm_ack = 1'b0;
        case (state)
            READ: begin
                ram_ce = STROBE_ON;
                ram_oe = STROBE_ON;
            end
            WR_SETUP, WR_HOLD: begin
                ram_ce = STROBE_ON;
                drive  = 1'b1;
            end
            WR_PULSE: begin
                ram_ce = STROBE_ON;
                ram_we = STROBE_ON;
                drive  = 1'b1;
            end
            DONE: begin
                if_ack = (gid_q == REQ_IF);
                dm_ack = (gid_q == REQ_DM);
            end
            default: ;
        endcase
    end

    assign ram_data = drive ? wdata_q : {DATA_WIDTH{1'bz}};

    // Latch request at grant, run the wait/pulse counter, capture read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gid_q    <= REQ_IF;
            wdata_q  <= '0;
            cnt      <= '0;
            ram_addr <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    gid_q    <= grant_id;
                    ram_addr <= (grant_id == REQ_DM) ? dm_addr : if_addr;
                    wdata_q  <= dm_wdata;
                    cnt      <= ram_read_wait;
                end
                READ: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (gid_q == REQ_IF) begin
                        if_rdata <= ram_data;
                    end else begin
                        dm_rdata <= ram_data;
                    end
                end
                WR_SETUP: cnt <= 8'(WRITE_CYCLES - 1);
                WR_PULSE: if (cnt != 8'd0) cnt <= cnt - 8'd1;
                default: ;
            endcase
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic if_served, dm_served, waiting;

    // A requester is "served" when granted now or owning the active transaction
    always_comb begin
        if_served = (state == IDLE) ? (take && grant_id == REQ_IF) : (gid_q == REQ_IF);
        dm_served = (state == IDLE) ? (take && grant_id == REQ_DM) : (gid_q == REQ_DM);
        waiting   = (if_req && !if_served) || (dm_req && !dm_served);
    end

    // Saturating grant and wait counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_if_grants   <= '0;
            stat_dm_grants   <= '0;
            stat_wait_cycles <= '0;
        end else begin
            if (take && grant_id == REQ_IF && stat_if_grants != 16'hFFFF)
                stat_if_grants <= stat_if_grants + 16'd1;
            if (take && grant_id == REQ_DM && stat_dm_grants != 16'hFFFF)
                stat_dm_grants <= stat_dm_grants + 16'd1;
            if (waiting && stat_wait_cycles != 16'hFFFF)
                stat_wait_cycles <= stat_wait_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM model.
`timescale 1ns/1ps
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  ram_read_wait = 8'd0;
    logic        if_req = 1'b0;
    logic [19:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [19:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic [19:0] ram_addr;
    wire  [31:0] ram_data;
    logic        ram_ce, ram_oe, ram_we;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0] stat_if_grants, stat_dm_grants, stat_wait_cycles;
`endif

    int errors = 0;
    int checks = 0;

    // per-transaction observations filled by do_txn
    int          t_ack, t_oe, t_we, t_acks;
    logic [2:0]  hist_str  [0:15];
    logic [31:0] hist_data [0:15];

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .ram_read_wait (ram_read_wait),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_rdata      (if_rdata),
        .if_ack        (if_ack),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_rdata      (dm_rdata),
        .dm_ack        (dm_ack),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .ram_ce        (ram_ce),
        .ram_oe        (ram_oe),
        .ram_we        (ram_we)
`ifdef SRAM_ARB_STATS_EN
        ,
        .stat_if_grants   (stat_if_grants),
        .stat_dm_grants   (stat_dm_grants),
        .stat_wait_cycles (stat_wait_cycles)
`endif
    );

    // SRAM model: drives on read, stores whatever is on the bus while we is low
    assign ram_data = (!ram_ce && !ram_oe && ram_we) ? mem[ram_addr[7:0]] : 32'hzzzz_zzzz;
    always @(posedge clk) if (!ram_ce && !ram_we) mem[ram_addr[7:0]] <= ram_data;

    // One transaction from IDLE; cycle c is the c-th cycle after the grant edge
    task automatic do_txn(input bit is_dm, input bit we, input logic [19:0] a,
                          input logic [31:0] d, input logic [7:0] rw);
        logic ack;
        @(negedge clk);
        ram_read_wait = rw;
        if (is_dm) begin dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d; end
        else       begin if_req = 1'b1; if_addr = a; end
        t_ack = -1; t_oe = 0; t_we = 0; t_acks = 0;
        for (int c = 1; c <= 300 && t_ack < 0; c++) begin
            @(negedge clk);
            if (c < 16) begin
                hist_str[c]  = {ram_ce, ram_oe, ram_we};
                hist_data[c] = ram_data;
            end
            if (!ram_oe) t_oe++;
            if (!ram_we) t_we++;
            ack = is_dm ? dm_ack : if_ack;
            if (ack) begin
                t_ack = c; t_acks++;
                dm_req = 1'b0; if_req = 1'b0;
            end
        end
        @(negedge clk);
        if ((is_dm ? dm_ack : if_ack)) t_acks++;
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({ram_ce, ram_oe, ram_we} !== 3'b111) begin errors++; $display("FAIL reset_strobes got=%b exp=111", {ram_ce, ram_oe, ram_we}); end
        checks++; if (ram_addr !== 20'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", ram_addr); end
        checks++; if ({if_ack, dm_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got=%b exp=00", {if_ack, dm_ack}); end
        checks++; if (if_rdata !== 32'd0 || dm_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, dm_rdata); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++; if (ram_ce !== 1'b1) begin errors++; $display("FAIL idle_ce got=%b exp=1", ram_ce); end
    endtask

    task automatic test_dm_write();
        do_txn(1'b1, 1'b1, 20'h00010, 32'hDEADBEEF, 8'd0);
        checks++; if (t_ack !== 5) begin errors++; $display("FAIL wr_ack_cycle got=%0d exp=5", t_ack); end
        checks++; if (t_we !== 2) begin errors++; $display("FAIL wr_we_cycles got=%0d exp=2", t_we); end
        checks++; if (t_oe !== 0) begin errors++; $display("FAIL wr_oe_cycles got=%0d exp=0", t_oe); end
        checks++; if (t_acks !== 1) begin errors++; $display("FAIL wr_ack_width got=%0d exp=1", t_acks); end
        checks++; if (hist_str[1] !== 3'b011 || hist_data[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_setup got=%b/%h exp=011/deadbeef", hist_str[1], hist_data[1]); end
        checks++; if (hist_str[2] !== 3'b010) begin errors++; $display("FAIL wr_pulse got=%b exp=010", hist_str[2]); end
        checks++; if (hist_str[4] !== 3'b011 || hist_data[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_hold got=%b/%h exp=011/deadbeef", hist_str[4], hist_data[4]); end
        checks++; if (hist_str[5] !== 3'b111) begin errors++; $display("FAIL wr_done got=%b exp=111", hist_str[5]); end
        checks++; if (mem[8'h10] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem got=%h exp=deadbeef", mem[8'h10]); end
    endtask

    task automatic test_dm_read();
        do_txn(1'b1, 1'b0, 20'h00010, 32'h0, 8'd0);
        checks++; if (t_ack !== 2) begin errors++; $display("FAIL rd_ack_cycle got=%0d exp=2", t_ack); end
        checks++; if (t_oe !== 1) begin errors++; $display("FAIL rd_oe_cycles got=%0d exp=1", t_oe); end
        checks++; if (hist_str[1] !== 3'b001) begin errors++; $display("FAIL rd_strobes got=%b exp=001", hist_str[1]); end
        checks++; if (dm_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", dm_rdata); end
    endtask

    task automatic test_if_read();
        do_txn(1'b1, 1'b1, 20'h00000, 32'h3C010001, 8'd0);
        do_txn(1'b0, 1'b0, 20'h00000, 32'h0, 8'd3);
        checks++; if (t_ack !== 5) begin errors++; $display("FAIL if_ack_cycle got=%0d exp=5", t_ack); end
        checks++; if (t_oe !== 4) begin errors++; $display("FAIL if_oe_cycles got=%0d exp=4", t_oe); end
        checks++; if (if_rdata !== 32'h3C010001) begin errors++; $display("FAIL if_data got=%h exp=3c010001", if_rdata); end
        checks++; if (dm_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dm_rdata_hold got=%h exp=deadbeef", dm_rdata); end
    endtask

    task automatic test_wait_255();
        do_txn(1'b1, 1'b1, 20'h00020, 32'hCAFEF00D, 8'd0);
        do_txn(1'b0, 1'b0, 20'h00020, 32'h0, 8'd255);
        checks++; if (t_ack !== 257) begin errors++; $display("FAIL w255_ack_cycle got=%0d exp=257", t_ack); end
        checks++; if (t_oe !== 256) begin errors++; $display("FAIL w255_oe_cycles got=%0d exp=256", t_oe); end
        checks++; if (if_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL w255_data got=%h exp=cafef00d", if_rdata); end
    endtask

    // Inputs change and req drops after grant: transaction still uses latched values
    task automatic test_drop_req();
        int got;
        do_txn(1'b1, 1'b1, 20'h00031, 32'h11111111, 8'd0);
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 20'h00030; dm_wdata = 32'h12345678;
        @(negedge clk);
        dm_req = 1'b0; dm_addr = 20'h00031; dm_wdata = 32'h0;
        got = -1;
        for (int c = 2; c <= 12 && got < 0; c++) begin
            @(negedge clk);
            if (dm_ack) got = c;
        end
        checks++; if (got !== 5) begin errors++; $display("FAIL drop_ack_cycle got=%0d exp=5", got); end
        checks++; if (mem[8'h30] !== 32'h12345678) begin errors++; $display("FAIL drop_mem30 got=%h exp=12345678", mem[8'h30]); end
        checks++; if (mem[8'h31] !== 32'h11111111) begin errors++; $display("FAIL drop_mem31 got=%h exp=11111111", mem[8'h31]); end
        @(negedge clk);
    endtask

    // Both ports hammering: dm, dm, if repeating, single-cycle acks
    task automatic test_starve();
        int n, dbl;
        logic prev_if, prev_dm;
        logic seq [0:5];
        logic exp_seq [0:5];
        exp_seq[0] = 1'b1; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0;
        exp_seq[3] = 1'b1; exp_seq[4] = 1'b1; exp_seq[5] = 1'b0;
        for (int i = 0; i < 6; i++) seq[i] = 1'bx;
        n = 0; dbl = 0; prev_if = 1'b0; prev_dm = 1'b0;
        @(negedge clk);
        ram_read_wait = 8'd0; if_addr = 20'h0; dm_addr = 20'h10; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            if ((if_ack && prev_if) || (dm_ack && prev_dm) || (if_ack && dm_ack)) dbl++;
            if (dm_ack && n < 6) begin seq[n] = 1'b1; n++; end
            if (if_ack && n < 6) begin seq[n] = 1'b0; n++; end
            prev_if = if_ack; prev_dm = dm_ack;
        end
        if_req = 1'b0; dm_req = 1'b0;
        checks++; if (n !== 6) begin errors++; $display("FAIL starve_count got=%0d exp=6", n); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (seq[i] !== exp_seq[i]) begin errors++; $display("FAIL starve_order[%0d] got=%b exp=%b (1=dm)", i, seq[i], exp_seq[i]); end
        end
        checks++; if (dbl !== 0) begin errors++; $display("FAIL starve_ack_width got=%0d exp=0", dbl); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 20'h00040; dm_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        @(negedge clk);
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL abort_in_pulse got=%b exp=0", ram_we); end
        rst = 1'b0;
        #1;
        checks++; if ({ram_ce, ram_oe, ram_we, dm_ack} !== 4'b1110) begin errors++; $display("FAIL abort_strobes got=%b exp=1110", {ram_ce, ram_oe, ram_we, dm_ack}); end
        dm_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({ram_ce, dm_ack} !== 2'b10) begin errors++; $display("FAIL abort_idle got=%b exp=10", {ram_ce, dm_ack}); end
        do_txn(1'b1, 1'b1, 20'h00040, 32'h5A5A5A5A, 8'd0);
        checks++; if (t_ack !== 5) begin errors++; $display("FAIL abort_rewrite_ack got=%0d exp=5", t_ack); end
        checks++; if (mem[8'h40] !== 32'h5A5A5A5A) begin errors++; $display("FAIL abort_rewrite_mem got=%h exp=5a5a5a5a", mem[8'h40]); end
    endtask

`ifdef SRAM_ARB_STATS_EN
    task automatic test_stats();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        checks++; if (stat_if_grants !== 16'd0) begin errors++; $display("FAIL stats_reset got=%0d exp=0", stat_if_grants); end
        for (int i = 0; i < 3; i++) do_txn(1'b0, 1'b0, 20'h00000, 32'h0, 8'd1);
        for (int i = 0; i < 2; i++) do_txn(1'b1, 1'b1, 20'h00050, 32'h0BAD0000 + 32'(i), 8'd0);
        checks++; if (stat_if_grants !== 16'd3) begin errors++; $display("FAIL stats_if got=%0d exp=3", stat_if_grants); end
        checks++; if (stat_dm_grants !== 16'd2) begin errors++; $display("FAIL stats_dm got=%0d exp=2", stat_dm_grants); end
        checks++; if (stat_wait_cycles !== 16'd0) begin errors++; $display("FAIL stats_wait got=%0d exp=0", stat_wait_cycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_dm_write();
        test_dm_read();
        test_if_read();
        test_wait_255();
        test_drop_req();
        test_starve();
        test_reset_abort();
`ifdef SRAM_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares one asynchronous 32-bit SRAM (baseram-style: 20-bit word address, active-low ce/oe/we, bidirectional data) between the CPU instruction-fetch port and the data-memory port. Arbitrates and sequences SRAM strobes with programmable read wait states and a fixed write pulse. Returns read data and a one-cycle ack per transaction. Sits inside system, between the CPU memory interfaces and the SRAM pins.

Parameters:
ADDR_WIDTH, 20, SRAM word address width
DATA_WIDTH, 32, SRAM data width
WRITE_CYCLES, 2, cycles ram_we is held low per write (min 1)
STARVE_LIMIT, 2, consecutive dmem grants allowed while ifetch is pending

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
ram_read_wait  in  8  extra read wait cycles; sampled at grant
if_req  in  1  instruction fetch request (read only)
if_addr  in  ADDR_WIDTH  fetch word address
if_rdata  out  DATA_WIDTH  fetch read data, valid with if_ack
if_ack  out  1  one-cycle completion pulse
dm_req  in  1  data request
dm_we  in  1  1=write, 0=read
dm_addr  in  ADDR_WIDTH  data word address
dm_wdata  in  DATA_WIDTH  write data
dm_rdata  out  DATA_WIDTH  read data, valid with dm_ack
dm_ack  out  1  one-cycle completion pulse
ram_addr  out  ADDR_WIDTH  SRAM address
ram_data  inout  DATA_WIDTH  SRAM data; driven only in write states, else Z
ram_ce  out  1  chip enable, active-low
ram_oe  out  1  output enable, active-low
ram_we  out  1  write enable, active-low

Behaviour:
- Reset (async, rst=0): ram_ce=ram_oe=ram_we=1, ram_data=Z, ram_addr=0, acks=0, rdata=0, state IDLE, starve count 0. Reset mid-transaction aborts it immediately; no ack is issued.
- FSM states: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: if any req is high, grant, latch addr/we/wdata/wait, set ram_addr. Read -> READ with counter = ram_read_wait. Write -> WR_SETUP.
- Priority: dm over if. Each dm grant while if_req=1 increments the starve count. When count = STARVE_LIMIT and if_req=1, if is granted and the count clears. An if grant also clears the count.
- READ: ce=0, oe=0, we=1. Stays (ram_read_wait+1) cycles. On the last cycle, ram_data is captured into the granted rdata register, then -> DONE.
- WR_SETUP: 1 cycle, ce=0, oe=1, we=1, data driven. WR_PULSE: WRITE_CYCLES cycles, we=0. WR_HOLD: 1 cycle, we=1, data still driven. Then -> DONE.
- DONE: 1 cycle, all strobes high, data Z. Granted ack=1 for exactly this cycle, then -> IDLE. No back-to-back without an idle-strobe cycle; this is the required bus turnaround.
- Latency from the grant edge: read ack at cycle ram_read_wait+2; write ack at cycle WRITE_CYCLES+3.
- Requesters hold req/addr/data stable until ack. Inputs are latched at grant, so later changes are ignored. Dropping req mid-transaction does not abort it, and the ack still pulses.
- A request still high in the cycle after its ack is treated as a new transaction.
- if_rdata/dm_rdata hold their last value until the next read for that port completes.
- ram_read_wait=255: 256 READ cycles, and the 8-bit counter must not wrap early.
- Simultaneous if_req and dm_req in IDLE with count < STARVE_LIMIT: dm wins.

Optional Feature:
SRAM_ARB_STATS_EN
- Defined: adds outputs stat_if_grants[15:0], stat_dm_grants[15:0], stat_wait_cycles[15:0]. The last counts cycles where a req is high but not granted. All counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sram_arb_pkg: state enum, requester-id constants (REQ_IF=0, REQ_DM=1), strobe-level constants (STROBE_ON=0, STROBE_OFF=1).
- Sub-module sram_arb_grant: combinational priority plus the starvation counter (registered). Inputs if_req, dm_req, grant_take. Outputs grant_id and grant_valid.
- FSM, strobes and data capture stay in the top module.

Test Plan:
- dm write addr 0x00010, data 0xDEADBEEF, WRITE_CYCLES=2 -> WR_SETUP 1 cycle, we low exactly 2 cycles, data driven through WR_HOLD, dm_ack at grant+5, ram_data Z afterwards.
- dm read 0x00010, ram_read_wait=0 -> oe low 1 cycle, dm_ack at grant+2, dm_rdata=0xDEADBEEF.
- ram_read_wait=3, if read 0x00000 preloaded 0x3C010001 -> oe low 4 cycles, if_ack at grant+5, if_rdata=0x3C010001.
- if_req and dm_req held high continuously, STARVE_LIMIT=2 -> grant order dm, dm, if, dm, dm, if; each ack is a single cycle.
- rst pulled low during WR_PULSE -> ce/we go high and data goes Z in the same cycle, no ack. After release the FSM is in IDLE and a repeated write completes normally.
- SRAM_ARB_STATS_EN defined, 3 if reads, 2 dm writes, no contention -> stat_if_grants=3, stat_dm_grants=2, stat_wait_cycles=0.
